func_sweep_checker: RTL and testbench
=====================================

Name: func_sweep_checker

Overview:
- Synthesizable, emulator-side stimulus/check engine for function-block unit tests. Replaces a simulation-only sweep loop.
- Drives a linear ramp on a fixed-point DUT input. Also drives a clipped copy of the ramp to a golden model.
- Compares N_CH DUT outputs against golden outputs after a settle interval. Accumulates sum-of-squared error and max absolute error, then reports pass/fail.
- Sits between the emulator control registers and the DUT/golden pair.

Parameters:
- WIDTH, 16, signed fixed-point width of stimulus, DUT outputs and golden outputs
- N_CH, 2, number of output channels checked in parallel
- CNT_W, 16, width of sample count and sample index
- SETTLE_W, 8, width of settle-cycle count
- ACC_W, 48, width of the saturating squared-error accumulator

Ports:
- emu_clk  input  1  emulator clock
- emu_rst_n  input  1  asynchronous active-low reset
- start  input  1  single-cycle request to begin a sweep
- in_start  input  WIDTH  signed first stimulus value
- in_step  input  WIDTH  signed increment per sample
- clip_min  input  WIDTH  signed lower clip bound
- clip_max  input  WIDTH  signed upper clip bound
- n_samp  input  CNT_W  number of sample points
- settle  input  SETTLE_W  extra hold cycles before each sample
- err_tol  input  WIDTH+1  unsigned per-sample absolute error tolerance
- sse_tol  input  ACC_W  unsigned sum-of-squared-error limit
- in_val  output  WIDTH  raw ramp to DUT
- in_clip  output  WIDTH  ramp clipped to [clip_min, clip_max], to golden model
- out_val  input  N_CH*WIDTH  packed DUT outputs, channel 0 in LSBs
- exp_val  input  N_CH*WIDTH  packed golden outputs, same packing
- busy  output  1  sweep in progress
- done  output  1  sweep complete; held until next accepted start
- pass  output  1  valid while done
- samp_cnt  output  CNT_W  samples taken
- sse  output  ACC_W  accumulated squared error
- max_err  output  WIDTH+1  largest absolute error seen

Behaviour:
- Interface: one clock, emu_clk. Reset emu_rst_n is asynchronous, active-low.
- Reset values: all outputs 0; state IDLE. Reset asserted mid-sweep aborts immediately to these values.
- States: IDLE, SETTLE, DONE.
- IDLE/DONE + start:
  - Latch all configuration inputs.
  - Load in_val=in_start.
  - Clear sse, max_err, samp_cnt, pass, done.
  - Load settle counter. Go to SETTLE with busy=1 from the next cycle.
- IDLE/DONE + start with n_samp==0: go directly to DONE with pass=1 and counters 0.
- start while in SETTLE is ignored. Mid-sweep configuration changes have no effect.
- Settle timing: each ramp point is held for settle+1 cycles. The sample is taken on the last of those cycles. settle=0 samples every cycle.
- Sample cycle, per channel:
  - diff = out - exp, computed at WIDTH+1 bits signed.
  - abs = |diff|, WIDTH+1 bits unsigned. The most-negative difference is representable, so no overflow.
  - sq = abs*abs, 2*(WIDTH+1) bits.
- Accumulation: sse += sum of sq over all channels, saturating at 2^ACC_W-1. max_err = max(max_err, abs over all channels). samp_cnt increments.
- After a sample:
  - If samp_cnt+1 == n_samp: go to DONE, busy=0, done=1.
  - Otherwise in_val += in_step, saturating at signed WIDTH limits, and the settle counter reloads.
- Clipping: in_clip = clip(in_val) combinationally, with zero latency relative to in_val. If clip_min > clip_max, in_clip = clip_min.
- pass = (max_err <= err_tol) && (sse <= sse_tol). It is registered on entry to DONE.
- sse, max_err and samp_cnt update on the cycle after each sample and stay stable in DONE.

Optional Feature:
- Macro SWEEP_FIRST_FAIL_EN.
- When defined, adds these outputs:
  - fail_idx (CNT_W): index of the first sample whose abs on any channel exceeds err_tol.
  - fail_ch ($clog2(N_CH) bits, min 1): lowest channel that failed at that sample.
  - fail_seen (1 bit).
- Captured once per sweep, cleared on accepted start, reset to 0.
- When not defined, these ports and registers do not exist. All other behaviour is identical.

Test Plan:
- WIDTH=16, N_CH=2. in_start=-100, in_step=10, n_samp=21, settle=2, out_val==exp_val.
  - done after exactly 63 busy cycles.
  - in_val ends at 100. sse=0, max_err=0, pass=1.
- Channel 1 out = exp+3 for all samples, err_tol=3, sse_tol=189.
  - sse=189, pass=1.
  - Repeat with sse_tol=188 -> pass=0.
- clip_min=-50, clip_max=50, ramp -100..100.
  - in_clip saturates at -50 for the first 5 points and at 50 for the last 5 points.
  - in_val stays unclipped.
- in_start=32760, in_step=10, n_samp=3 -> in_val sequence 32760, 32767, 32767.
- Pulse start mid-sweep -> ignored, count unchanged. Assert emu_rst_n=0 mid-sweep -> all outputs 0 asynchronously.
- With SWEEP_FIRST_FAIL_EN: channel 0 error 5 at sample 7 only, err_tol=2 -> fail_idx=7, fail_ch=0, fail_seen=1, pass=0.

Source files
------------

// File: rtl/func_sweep_checker.sv
// Ramp stimulus / output-compare engine for emulated function-block tests.
// Optional first-failure capture outputs are enabled by defining SWEEP_FIRST_FAIL_EN.
module func_sweep_checker #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned N_CH     = 2,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned SETTLE_W = 8,
    parameter int unsigned ACC_W    = 48,
    localparam int unsigned FCH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                    emu_clk,
    input  logic                    emu_rst_n,
    input  logic                    start,
    input  logic [WIDTH-1:0]        in_start,
    input  logic [WIDTH-1:0]        in_step,
    input  logic [WIDTH-1:0]        clip_min,
    input  logic [WIDTH-1:0]        clip_max,
    input  logic [CNT_W-1:0]        n_samp,
    input  logic [SETTLE_W-1:0]     settle,
    input  logic [WIDTH:0]          err_tol,
    input  logic [ACC_W-1:0]        sse_tol,
    output logic [WIDTH-1:0]        in_val,
    output logic [WIDTH-1:0]        in_clip,
    input  logic [N_CH*WIDTH-1:0]   out_val,
    input  logic [N_CH*WIDTH-1:0]   exp_val,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [CNT_W-1:0]        samp_cnt,
    output logic [ACC_W-1:0]        sse,
    output logic [WIDTH:0]          max_err
`ifdef SWEEP_FIRST_FAIL_EN
    ,
    output logic [CNT_W-1:0]        fail_idx,
    output logic [FCH_W-1:0]        fail_ch,
    output logic                    fail_seen
`endif
);

    localparam int unsigned AW    = WIDTH + 1;
    localparam int unsigned SQ_W  = 2 * AW;
    localparam int unsigned SUM_W = SQ_W + $clog2(N_CH + 1);
    localparam int unsigned EXT_W = ((ACC_W > SUM_W) ? ACC_W : SUM_W) + 1;

    localparam logic [ACC_W-1:0] ACC_MAX = '1;
    localparam logic [WIDTH-1:0] S_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] S_MIN   = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic signed [WIDTH-1:0]   in_val_q, in_val_d;
    logic signed [WIDTH-1:0]   step_q, step_d;
    logic signed [WIDTH-1:0]   clip_min_q, clip_min_d;
    logic signed [WIDTH-1:0]   clip_max_q, clip_max_d;
    logic [CNT_W-1:0]          n_samp_q, n_samp_d;
    logic [SETTLE_W-1:0]       settle_q, settle_d;
    logic [SETTLE_W-1:0]       settle_cnt_q, settle_cnt_d;
    logic [WIDTH:0]            err_tol_q, err_tol_d;
    logic [ACC_W-1:0]          sse_tol_q, sse_tol_d;
    logic [CNT_W-1:0]          samp_cnt_q, samp_cnt_d;
    logic [ACC_W-1:0]          sse_q, sse_d;
    logic [WIDTH:0]            max_err_q, max_err_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      pass_q, pass_d;
`ifdef SWEEP_FIRST_FAIL_EN
    logic [CNT_W-1:0]          fail_idx_q, fail_idx_d;
    logic [FCH_W-1:0]          fail_ch_q, fail_ch_d;
    logic                      fail_seen_q, fail_seen_d;
    logic                      any_fail_c;
    logic [FCH_W-1:0]          first_ch_c;
`endif

    logic signed [AW-1:0]      diff_c;
    logic [AW-1:0]             abs_c;
    logic [SQ_W-1:0]           sq_c;
    logic [SUM_W-1:0]          sq_sum_c;
    logic [AW-1:0]             max_abs_c;
    logic [EXT_W-1:0]          sse_ext_c;
    logic [ACC_W-1:0]          sse_sat_c;
    logic signed [AW-1:0]      ramp_sum_c;
    logic signed [WIDTH-1:0]   ramp_next_c;
    logic signed [WIDTH-1:0]   in_clip_c;

    // Per-channel error, squared-error sum and running max; descending scan leaves the lowest failing channel.
    always_comb begin
        diff_c    = '0;
        abs_c     = '0;
        sq_c      = '0;
        sq_sum_c  = '0;
        max_abs_c = max_err_q;
`ifdef SWEEP_FIRST_FAIL_EN
        any_fail_c = 1'b0;
        first_ch_c = '0;
`endif
        for (int c = int'(N_CH) - 1; c >= 0; c--) begin
            diff_c   = AW'($signed(out_val[c*WIDTH +: WIDTH])) - AW'($signed(exp_val[c*WIDTH +: WIDTH]));
            abs_c    = diff_c[WIDTH] ? unsigned'(-diff_c) : unsigned'(diff_c);
            sq_c     = {{AW{1'b0}}, abs_c} * {{AW{1'b0}}, abs_c};
            sq_sum_c = sq_sum_c + SUM_W'(sq_c);
            if (abs_c > max_abs_c) begin
                max_abs_c = abs_c;
            end
`ifdef SWEEP_FIRST_FAIL_EN
            if (abs_c > err_tol_q) begin
                any_fail_c = 1'b1;
                first_ch_c = FCH_W'(c);
            end
`endif
        end
        sse_ext_c = EXT_W'(sse_q) + EXT_W'(sq_sum_c);
        sse_sat_c = (sse_ext_c > EXT_W'(ACC_MAX)) ? ACC_MAX : sse_ext_c[ACC_W-1:0];
    end

    // Next ramp point, saturating at the signed range limits.
    always_comb begin
        ramp_sum_c = AW'(in_val_q) + AW'(step_q);
        if (ramp_sum_c[WIDTH] != ramp_sum_c[WIDTH-1]) begin
            ramp_next_c = ramp_sum_c[WIDTH] ? S_MIN : S_MAX;
        end else begin
            ramp_next_c = ramp_sum_c[WIDTH-1:0];
        end
    end

    // Golden-model stimulus; an inverted window pins to clip_min.
    always_comb begin
        if (clip_min_q > clip_max_q) begin
            in_clip_c = clip_min_q;
        end else if (in_val_q < clip_min_q) begin
            in_clip_c = clip_min_q;
        end else if (in_val_q > clip_max_q) begin
            in_clip_c = clip_max_q;
        end else begin
            in_clip_c = in_val_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        in_val_d     = in_val_q;
        step_d       = step_q;
        clip_min_d   = clip_min_q;
        clip_max_d   = clip_max_q;
        n_samp_d     = n_samp_q;
        settle_d     = settle_q;
        settle_cnt_d = settle_cnt_q;
        err_tol_d    = err_tol_q;
        sse_tol_d    = sse_tol_q;
        samp_cnt_d   = samp_cnt_q;
        sse_d        = sse_q;
        max_err_d    = max_err_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
`ifdef SWEEP_FIRST_FAIL_EN
        fail_idx_d   = fail_idx_q;
        fail_ch_d    = fail_ch_q;
        fail_seen_d  = fail_seen_q;
`endif
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    in_val_d     = in_start;
                    step_d       = in_step;
                    clip_min_d   = clip_min;
                    clip_max_d   = clip_max;
                    n_samp_d     = n_samp;
                    settle_d     = settle;
                    settle_cnt_d = settle;
                    err_tol_d    = err_tol;
                    sse_tol_d    = sse_tol;
                    samp_cnt_d   = '0;
                    sse_d        = '0;
                    max_err_d    = '0;
                    pass_d       = 1'b0;
                    done_d       = 1'b0;
`ifdef SWEEP_FIRST_FAIL_EN
                    fail_idx_d   = '0;
                    fail_ch_d    = '0;
                    fail_seen_d  = 1'b0;
`endif
                    if (n_samp == '0) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_SETTLE;
                        busy_d  = 1'b1;
                    end
                end
            end
            ST_SETTLE: begin
                if (settle_cnt_q != '0) begin
                    settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
                end else begin
                    sse_d      = sse_sat_c;
                    max_err_d  = max_abs_c;
                    samp_cnt_d = samp_cnt_q + CNT_W'(1);
`ifdef SWEEP_FIRST_FAIL_EN
                    if (!fail_seen_q && any_fail_c) begin
                        fail_idx_d  = samp_cnt_q;
                        fail_ch_d   = first_ch_c;
                        fail_seen_d = 1'b1;
                    end
`endif
                    if (samp_cnt_d == n_samp_q) begin
                        state_d = ST_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = (max_err_d <= err_tol_q) && (sse_d <= sse_tol_q);
                    end else begin
                        in_val_d     = ramp_next_c;
                        settle_cnt_d = settle_q;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge emu_clk or negedge emu_rst_n) begin
        if (!emu_rst_n) begin
            state_q      <= ST_IDLE;
            in_val_q     <= '0;
            step_q       <= '0;
            clip_min_q   <= '0;
            clip_max_q   <= '0;
            n_samp_q     <= '0;
            settle_q     <= '0;
            settle_cnt_q <= '0;
            err_tol_q    <= '0;
            sse_tol_q    <= '0;
            samp_cnt_q   <= '0;
            sse_q        <= '0;
            max_err_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
`ifdef SWEEP_FIRST_FAIL_EN
            fail_idx_q   <= '0;
            fail_ch_q    <= '0;
            fail_seen_q  <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            in_val_q     <= in_val_d;
            step_q       <= step_d;
            clip_min_q   <= clip_min_d;
            clip_max_q   <= clip_max_d;
            n_samp_q     <= n_samp_d;
            settle_q     <= settle_d;
            settle_cnt_q <= settle_cnt_d;
            err_tol_q    <= err_tol_d;
            sse_tol_q    <= sse_tol_d;
            samp_cnt_q   <= samp_cnt_d;
            sse_q        <= sse_d;
            max_err_q    <= max_err_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
`ifdef SWEEP_FIRST_FAIL_EN
            fail_idx_q   <= fail_idx_d;
            fail_ch_q    <= fail_ch_d;
            fail_seen_q  <= fail_seen_d;
`endif
        end
    end

    assign in_val   = in_val_q;
    assign in_clip  = in_clip_c;
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
    assign samp_cnt = samp_cnt_q;
    assign sse      = sse_q;
    assign max_err  = max_err_q;
`ifdef SWEEP_FIRST_FAIL_EN
    assign fail_idx  = fail_idx_q;
    assign fail_ch   = fail_ch_q;
    assign fail_seen = fail_seen_q;
`endif

endmodule

// File: tb/tb_func_sweep_checker.sv
// Directed bench for func_sweep_checker; first-failure checks run when SWEEP_FIRST_FAIL_EN is defined.
module tb_func_sweep_checker;

    localparam int W  = 16;
    localparam int NC = 2;
    localparam int CW = 16;
    localparam int SW = 8;
    localparam int AW = 48;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [W-1:0]      in_start = '0;
    logic [W-1:0]      in_step = '0;
    logic [W-1:0]      clip_min = '0;
    logic [W-1:0]      clip_max = '0;
    logic [CW-1:0]     n_samp = '0;
    logic [SW-1:0]     settle = '0;
    logic [W:0]        err_tol = '0;
    logic [AW-1:0]     sse_tol = '0;
    logic [W-1:0]      in_val;
    logic [W-1:0]      in_clip;
    logic [NC*W-1:0]   out_val;
    logic [NC*W-1:0]   exp_val;
    logic              busy;
    logic              done;
    logic              pass;
    logic [CW-1:0]     samp_cnt;
    logic [AW-1:0]     sse;
    logic [W:0]        max_err;
`ifdef SWEEP_FIRST_FAIL_EN
    logic [CW-1:0]     fail_idx;
    logic [0:0]        fail_ch;
    logic              fail_seen;
`endif

    logic [W-1:0]      ch0_exp = 16'd100;
    logic [W-1:0]      ch1_exp = 16'd200;
    logic [W-1:0]      ch1_off = 16'd0;
    logic              inj = 1'b0;

    assign exp_val = {ch1_exp, ch0_exp};
    assign out_val = {ch1_exp + ch1_off, ch0_exp + ((inj && samp_cnt == 16'd7) ? 16'd5 : 16'd0)};

    int checks = 0;
    int errors = 0;
    int busy_cyc;
    logic signed [W-1:0] rec_val  [0:255];
    logic signed [W-1:0] rec_clip [0:255];

    always #5 clk = ~clk;

    func_sweep_checker dut (
        .emu_clk   (clk),
        .emu_rst_n (rst_n),
        .start     (start),
        .in_start  (in_start),
        .in_step   (in_step),
        .clip_min  (clip_min),
        .clip_max  (clip_max),
        .n_samp    (n_samp),
        .settle    (settle),
        .err_tol   (err_tol),
        .sse_tol   (sse_tol),
        .in_val    (in_val),
        .in_clip   (in_clip),
        .out_val   (out_val),
        .exp_val   (exp_val),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .samp_cnt  (samp_cnt),
        .sse       (sse),
        .max_err   (max_err)
`ifdef SWEEP_FIRST_FAIL_EN
        ,
        .fail_idx  (fail_idx),
        .fail_ch   (fail_ch),
        .fail_seen (fail_seen)
`endif
    );

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Runs one sweep; optionally re-pulses start with different config at busy cycle 'poke'.
    task automatic sweep(input int s0, input int st, input int cmin, input int cmax,
                         input int ns, input int stl, input int tol, input longint stol,
                         input int poke);
        in_start = 16'(s0);
        in_step  = 16'(st);
        clip_min = 16'(cmin);
        clip_max = 16'(cmax);
        n_samp   = 16'(ns);
        settle   = 8'(stl);
        err_tol  = 17'(tol);
        sse_tol  = 48'(stol);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_cyc = 0;
        for (int i = 0; i < 2000 && !done; i++) begin
            if (busy) begin
                if (busy_cyc < 256) begin
                    rec_val[busy_cyc]  = $signed(in_val);
                    rec_clip[busy_cyc] = $signed(in_clip);
                end
                busy_cyc++;
            end
            if (i == poke) begin
                start    = 1'b1;
                in_start = 16'd0;
                n_samp   = 16'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("sweep_done", 64'(done), 64'd1);
    endtask

    initial begin
        #1;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_done", 64'(done), 0);
        chk("rst_inval", 64'($signed(in_val)), 0);
        chk("rst_sse", 64'(sse), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Matched outputs, ramp -100..100 with clip window [-50,50]
        sweep(-100, 10, -50, 50, 21, 2, 0, 0, -1);
        chk("t1_busy_cycles", 64'(busy_cyc), 63);
        chk("t1_inval_end", 64'($signed(in_val)), 100);
        chk("t1_samp", 64'(samp_cnt), 21);
        chk("t1_sse", 64'(sse), 0);
        chk("t1_maxerr", 64'(max_err), 0);
        chk("t1_pass", 64'(pass), 1);
        chk("t1_busy_low", 64'(busy), 0);
        chk("t1_val_p0", 64'(rec_val[0]), -100);
        chk("t1_clip_p0", 64'(rec_clip[0]), -50);
        chk("t1_clip_p4", 64'(rec_clip[12]), -50);
        chk("t1_val_p4", 64'(rec_val[12]), -60);
        chk("t1_clip_p10", 64'(rec_clip[30]), 0);
        chk("t1_val_p16", 64'(rec_val[48]), 60);
        chk("t1_clip_p16", 64'(rec_clip[48]), 50);
        chk("t1_clip_p20", 64'(rec_clip[60]), 50);
        chk("t1_val_p20", 64'(rec_val[60]), 100);

        // Channel 1 off by +3 on every sample: sse = 21*9 = 189
        ch1_off = 16'd3;
        sweep(-100, 10, -50, 50, 21, 2, 3, 189, -1);
        chk("t2_sse", 64'(sse), 189);
        chk("t2_maxerr", 64'(max_err), 3);
        chk("t2_pass", 64'(pass), 1);
        sweep(-100, 10, -50, 50, 21, 2, 3, 188, -1);
        chk("t2b_sse", 64'(sse), 189);
        chk("t2b_pass", 64'(pass), 0);
        ch1_off = 16'd0;

        // Positive saturation of the ramp
        sweep(32760, 10, -32768, 32767, 3, 0, 0, 0, -1);
        chk("t3_busy_cycles", 64'(busy_cyc), 3);
        chk("t3_val0", 64'(rec_val[0]), 32760);
        chk("t3_val1", 64'(rec_val[1]), 32767);
        chk("t3_val2", 64'(rec_val[2]), 32767);
        chk("t3_clip2", 64'(rec_clip[2]), 32767);

        // n_samp == 0 goes straight to done; inverted clip window pins to clip_min
        sweep(0, 1, 10, -10, 0, 0, 0, 0, -1);
        chk("t4_busy_cycles", 64'(busy_cyc), 0);
        chk("t4_pass", 64'(pass), 1);
        chk("t4_samp", 64'(samp_cnt), 0);
        chk("t4_clip_inv", 64'($signed(in_clip)), 10);

        // Start pulsed mid-sweep with new config is ignored
        sweep(-100, 10, -50, 50, 21, 2, 0, 0, 10);
        chk("t5_busy_cycles", 64'(busy_cyc), 63);
        chk("t5_samp", 64'(samp_cnt), 21);
        chk("t5_inval_end", 64'($signed(in_val)), 100);

        // Channel 0 error of 5 at sample 7 only
        inj = 1'b1;
        sweep(0, 1, -50, 50, 10, 1, 2, 1000, -1);
        chk("t6_busy_cycles", 64'(busy_cyc), 20);
        chk("t6_sse", 64'(sse), 25);
        chk("t6_maxerr", 64'(max_err), 5);
        chk("t6_pass", 64'(pass), 0);
`ifdef SWEEP_FIRST_FAIL_EN
        chk("t6_fail_idx", 64'(fail_idx), 7);
        chk("t6_fail_ch", 64'(fail_ch), 0);
        chk("t6_fail_seen", 64'(fail_seen), 1);
`endif
        inj = 1'b0;

        // Asynchronous reset mid-sweep
        in_start = 16'd50;
        n_samp   = 16'd21;
        settle   = 8'd2;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        chk("t7_busy_before", 64'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t7_busy", 64'(busy), 0);
        chk("t7_inval", 64'($signed(in_val)), 0);
        chk("t7_inclip", 64'($signed(in_clip)), 0);
        chk("t7_samp", 64'(samp_cnt), 0);
        chk("t7_done", 64'(done), 0);
        chk("t7_pass", 64'(pass), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
